// File: rtl/alu_arbiter_if.sv
// Bus bundle for alu_arbiter: two requester ports, the shared-ALU side and the response port.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface alu_arbiter_if #(parameter int WIDTH = 32);
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_op,    req1_op;
    logic [WIDTH-1:0] req0_a,     req1_a;
    logic [WIDTH-1:0] req0_b,     req1_b;

    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero, rsp_err;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
        output req0_ready, req1_ready,
        output alu_ctl, alu_a, alu_b,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
        input  req0_ready, req1_ready,
        input  alu_ctl, alu_a, alu_b,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_FIXED_PRIO_EN to resolve ties always toward req0 instead of round-robin.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] OP_ADD = 4'b0010;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             last_grant_q, last_grant_d;
`endif

    logic [1:0]       vld, gnt;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] alu_a, alu_b;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0110, 4'b1001: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    assign vld = {bus.req1_valid, bus.req0_valid};

    // Grant is only ever raised for a currently-valid requester, so ready implies accept.
    always_comb begin
        gnt = 2'b00;
        if (state_q == IDLE) begin
            case (vld)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
                2'b11:   gnt = 2'b01;
`else
                2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
`endif
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        res_d   = res_q;
        zero_d  = zero_q;
        err_d   = err_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        alu_ctl = OP_ADD;
        alu_a   = '0;
        alu_b   = '0;

        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d = EXEC;
                    id_d    = gnt[1];
                    op_d    = gnt[1] ? bus.req1_op : bus.req0_op;
                    a_d     = gnt[1] ? bus.req1_a  : bus.req0_a;
                    b_d     = gnt[1] ? bus.req1_b  : bus.req0_b;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant_d = gnt[1];
`endif
                end
            end
            EXEC: begin
                // Illegal ops still occupy an ALU slot, but their result is squashed.
                alu_ctl = op_legal(op_q) ? op_q : OP_ADD;
                alu_a   = a_q;
                alu_b   = b_q;
                res_d   = op_legal(op_q) ? bus.alu_result : '0;
                zero_d  = op_legal(op_q) & bus.alu_zero;
                err_d   = ~op_legal(op_q);
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.alu_ctl    = alu_ctl;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;

endmodule
